// File: rtl/megarom_cfg_pkg.sv
// Shared constants, types and reset defaults for the multi-bank megarom
// configuration window and its unlock state machine.
package megarom_cfg_pkg;

   localparam int MAX_BANKS = 8;

   localparam logic [7:0] KEY_0 = 8'hAB;
   localparam logic [7:0] KEY_1 = 8'hCD;
   localparam logic [7:0] KEY_2 = 8'h98;
   localparam logic [7:0] KEY_3 = 8'h76;

   localparam logic [7:0] OFF_KEY         = 8'h00;
   localparam logic [7:0] OFF_LOCK        = 8'h01;
   localparam logic [7:0] OFF_COMMIT      = 8'h0B;
   localparam logic [7:0] OFF_FLAGS       = 8'h0C;
   localparam logic [7:0] OFF_BANK_MASK   = 8'h0D;
   localparam logic [7:0] OFF_ADDR_MASK_L = 8'h0E;
   localparam logic [7:0] OFF_ADDR_MASK_H = 8'h0F;
   localparam logic [7:0] OFF_BANK_BASE   = 8'h10;

   localparam int FLAG_WP   = 0;
   localparam int FLAG_16K  = 1;
   localparam int FLAG_CS1M = 2;
   localparam int FLAG_CS2M = 3;
   localparam int FLAG_SCC  = 4;
   localparam int FLAG_EC   = 6;
   localparam int FLAG_EN   = 7;

   localparam logic [7:0]  FLAGS_RESET     = 8'h0F;
   localparam logic [15:0] BANK_ADDR_RESET = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_LOCKED   = 3'd0,
      ST_K1       = 3'd1,
      ST_K2       = 3'd2,
      ST_K3       = 3'd3,
      ST_UNLOCKED = 3'd4
   } unlock_state_t;

   typedef struct packed {
      logic [7:0]                  flags;
      logic [7:0]                  bank_mask;
      logic [15:0]                 addr_mask;
      logic [MAX_BANKS-1:0][15:0]  bank_addr;
      logic [MAX_BANKS-1:0][7:0]   bank_init;
      logic [MAX_BANKS-1:0][7:0]   bank_rsv;
   } megarom_cfg_t;

   localparam megarom_cfg_t CFG_RESET = '{
      flags:     FLAGS_RESET,
      bank_mask: 8'h00,
      addr_mask: 16'h0000,
      bank_addr: {MAX_BANKS{BANK_ADDR_RESET}},
      bank_init: {MAX_BANKS{8'h00}},
      bank_rsv:  {MAX_BANKS{8'h00}}
   };

   function automatic logic [7:0] status_byte(input logic [3:0] nbanks,
                                              input logic       pending,
                                              input logic       unlocked);
      return {nbanks, 2'b00, pending, unlocked};
   endfunction

endpackage

// File: rtl/megarom_configure_multi_unlock_fsm.sv
// Key-sequence unlock state machine with optional idle-timeout relock.
module megarom_unlock_fsm
   import megarom_cfg_pkg::*;
#(
   parameter int UNLOCK_TIMEOUT = 0
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       bus_reset,
   input  logic       key_wr,
   input  logic       lock_wr,
   input  logic       acc_wr,
   input  logic [7:0] key,
   output logic       unlocked
);

   localparam logic [23:0] TIMEOUT_C = 24'(UNLOCK_TIMEOUT);

   unlock_state_t state_r;
   logic [23:0]   idle_cnt_r;
   logic [23:0]   idle_nxt_s;
   logic          timeout_s;

   assign idle_nxt_s = idle_cnt_r + 24'd1;
   assign timeout_s  = (TIMEOUT_C != 24'd0) && (idle_nxt_s == TIMEOUT_C);
   assign unlocked   = (state_r == ST_UNLOCKED);

   // Key sequencing, explicit relock and idle-timeout relock.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r    <= ST_LOCKED;
         idle_cnt_r <= 24'd0;
      end else if (bus_reset || lock_wr) begin
         state_r    <= ST_LOCKED;
         idle_cnt_r <= 24'd0;
      end else if (state_r == ST_UNLOCKED) begin
         if (acc_wr) begin
            idle_cnt_r <= 24'd0;
         end else if (timeout_s) begin
            state_r    <= ST_LOCKED;
            idle_cnt_r <= 24'd0;
         end else begin
            idle_cnt_r <= idle_nxt_s;
         end
      end else begin
         idle_cnt_r <= 24'd0;
         if (key_wr) begin
            // A stray KEY_0 restarts the sequence instead of dropping it.
            case (state_r)
               ST_LOCKED: state_r <= (key == KEY_0) ? ST_K1 : ST_LOCKED;
               ST_K1:     state_r <= (key == KEY_1) ? ST_K2 :
                                     (key == KEY_0) ? ST_K1 : ST_LOCKED;
               ST_K2:     state_r <= (key == KEY_2) ? ST_K3 :
                                     (key == KEY_0) ? ST_K1 : ST_LOCKED;
               ST_K3:     state_r <= (key == KEY_3) ? ST_UNLOCKED :
                                     (key == KEY_0) ? ST_K1 : ST_LOCKED;
               default:   state_r <= ST_LOCKED;
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: rtl/megarom_configure_multi.sv
// Megarom configuration window: bus-side shadow registers behind a key lock,
// committed atomically into the active copy that drives the mapper.
module megarom_configure_multi
   import megarom_cfg_pkg::*;
#(
   parameter int          NUM_BANKS      = 4,
   parameter logic [15:0] BASE_ADDR      = 16'h0000,
   parameter logic [31:0] RAM_ADDR       = 32'h0000_0000,
   parameter int          UNLOCK_TIMEOUT = 0
) (
   input  logic                    CLK,
   input  logic                    RESET_n,
   input  logic                    BUS_RESET_n,
   input  logic                    SLTSL_n,
   input  logic                    MERQ_n,
   input  logic                    RD_n,
   input  logic                    WR_n,
   input  logic [15:0]             ADDR,
   input  logic [7:0]              DIN,
   output logic [7:0]              DOUT,
   output logic                    BUSDIR_n,
   output logic                    INT_n,
   output logic                    WAIT_n,
   output logic [16*NUM_BANKS-1:0] BANK_ADDR,
   output logic [8*NUM_BANKS-1:0]  BANK_INIT,
   output logic [15:0]             BANK_ADDR_MASK,
   output logic [7:0]              BANK_MASK,
   output logic                    WRITE_PROTECT,
   output logic                    IS_16K_BANK,
   output logic                    CS1_MASK,
   output logic                    CS2_MASK,
   output logic                    SCC_ENA,
   output logic [31:0]             MEM_TOP_ADDR,
   output logic                    LOCKED
);

   localparam int         WIN_BITS = $clog2(16 + 4 * NUM_BANKS);
   localparam logic [7:0] MAP_END  = 8'(16 + 4 * NUM_BANKS);

   logic         rd_s, wr_s, in_win_s, wr_edge_s, bus_reset_s;
   logic         unlocked_s, key_wr_s, lock_wr_s, acc_wr_s, is_bank_s, rd_ok_s;
   logic [7:0]   off_s, bank_off_s, rdata_s;
   logic [2:0]   bank_idx_s;
   logic         prev_wr_r, pending_r, busdir_n_r;
   logic [7:0]   dout_r;
   megarom_cfg_t shadow_r, active_r;
   logic         unused_cfg_s;

   assign rd_s        = !SLTSL_n && !MERQ_n && !RD_n;
   assign wr_s        = !SLTSL_n && !MERQ_n && !WR_n;
   assign in_win_s    = (ADDR[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
   assign off_s       = {{(8 - WIN_BITS){1'b0}}, ADDR[WIN_BITS-1:0]};
   assign bus_reset_s = !BUS_RESET_n;
   assign wr_edge_s   = wr_s && !prev_wr_r && in_win_s;
   assign key_wr_s    = wr_edge_s && (off_s == OFF_KEY);
   assign lock_wr_s   = wr_edge_s && (off_s == OFF_LOCK);
   assign acc_wr_s    = wr_edge_s && unlocked_s;
   assign bank_off_s  = off_s - OFF_BANK_BASE;
   assign bank_idx_s  = bank_off_s[4:2];
   assign is_bank_s   = (off_s >= OFF_BANK_BASE) && (off_s < MAP_END);
   assign rd_ok_s     = rd_s && in_win_s && (unlocked_s || (off_s == OFF_KEY));

   megarom_unlock_fsm #(
      .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
   ) u_unlock_fsm (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .bus_reset (bus_reset_s),
      .key_wr    (key_wr_s),
      .lock_wr   (lock_wr_s),
      .acc_wr    (acc_wr_s),
      .key       (DIN),
      .unlocked  (unlocked_s)
   );

   // Read mux over the shadow copy; unmapped offsets read as zero.
   always_comb begin
      rdata_s = 8'h00;
      case (off_s)
         OFF_KEY:         rdata_s = status_byte(4'(NUM_BANKS), pending_r, unlocked_s);
         OFF_FLAGS:       rdata_s = shadow_r.flags;
         OFF_BANK_MASK:   rdata_s = shadow_r.bank_mask;
         OFF_ADDR_MASK_L: rdata_s = shadow_r.addr_mask[7:0];
         OFF_ADDR_MASK_H: rdata_s = shadow_r.addr_mask[15:8];
         default: begin
            if (is_bank_s) begin
               case (bank_off_s[1:0])
                  2'd0:    rdata_s = shadow_r.bank_addr[bank_idx_s][7:0];
                  2'd1:    rdata_s = shadow_r.bank_addr[bank_idx_s][15:8];
                  2'd2:    rdata_s = shadow_r.bank_init[bank_idx_s];
                  default: rdata_s = shadow_r.bank_rsv[bank_idx_s];
               endcase
            end else begin
               rdata_s = 8'h00;
            end
         end
      endcase
   end

   // Registered read response, one cycle behind the strobe.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         dout_r     <= 8'h00;
         busdir_n_r <= 1'b1;
      end else if (rd_ok_s) begin
         dout_r     <= rdata_s;
         busdir_n_r <= 1'b0;
      end else begin
         dout_r     <= 8'h00;
         busdir_n_r <= 1'b1;
      end
   end

   // Shadow writes, commit into active, and bus-reset handling of ENABLE.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         shadow_r  <= CFG_RESET;
         active_r  <= CFG_RESET;
         pending_r <= 1'b0;
         prev_wr_r <= 1'b1;
      end else if (bus_reset_s) begin
         pending_r <= 1'b0;
         prev_wr_r <= 1'b1;
         if (!active_r.flags[FLAG_EC]) begin
            shadow_r.flags[FLAG_EN] <= 1'b0;
            active_r.flags[FLAG_EN] <= 1'b0;
         end
      end else begin
         prev_wr_r <= wr_s;
         if (pending_r) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
         end
         if (acc_wr_s) begin
            case (off_s)
               OFF_COMMIT:      if (DIN[0]) pending_r <= 1'b1;
               OFF_FLAGS:       shadow_r.flags           <= DIN;
               OFF_BANK_MASK:   shadow_r.bank_mask       <= DIN;
               OFF_ADDR_MASK_L: shadow_r.addr_mask[7:0]  <= DIN;
               OFF_ADDR_MASK_H: shadow_r.addr_mask[15:8] <= DIN;
               default: begin
                  if (is_bank_s) begin
                     case (bank_off_s[1:0])
                        2'd0:    shadow_r.bank_addr[bank_idx_s][7:0]  <= DIN;
                        2'd1:    shadow_r.bank_addr[bank_idx_s][15:8] <= DIN;
                        2'd2:    shadow_r.bank_init[bank_idx_s]       <= DIN;
                        default: shadow_r.bank_rsv[bank_idx_s]        <= DIN;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   genvar i;
   for (i = 0; i < NUM_BANKS; i++) begin : g_bank
      assign BANK_ADDR[16*i +: 16] = active_r.bank_addr[i];
      assign BANK_INIT[8*i +: 8]   = active_r.bank_init[i];
   end

   assign DOUT           = dout_r;
   assign BUSDIR_n       = busdir_n_r;
   assign INT_n          = 1'b1;
   assign WAIT_n         = 1'b1;
   assign BANK_ADDR_MASK = active_r.addr_mask;
   assign BANK_MASK      = active_r.bank_mask;
   assign WRITE_PROTECT  = active_r.flags[FLAG_WP];
   assign IS_16K_BANK    = active_r.flags[FLAG_16K];
   assign SCC_ENA        = active_r.flags[FLAG_SCC];
   // Chip-select masks are forced while the mapper is disabled.
   assign CS1_MASK       = active_r.flags[FLAG_CS1M] || !active_r.flags[FLAG_EN];
   assign CS2_MASK       = active_r.flags[FLAG_CS2M] || !active_r.flags[FLAG_EN];
   assign MEM_TOP_ADDR   = RAM_ADDR;
   assign LOCKED         = !unlocked_s;
   assign unused_cfg_s   = ^active_r;

endmodule

// File: tb/tb_megarom_configure_multi.sv
// Randomised bench for megarom_configure_multi against a byte-array model.
module tb_megarom_configure_multi;

   localparam int          NB   = 8;
   localparam logic [15:0] BASE = 16'h7FC0;
   localparam int          TMO  = 100;
   localparam logic [31:0] RADDR = 32'h0123_4000;

   logic CLK = 1'b0, RESET_n = 1'b0, BUS_RESET_n = 1'b1;
   logic SLTSL_n = 1'b1, MERQ_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic [7:0]  DIN = 8'h00;
   logic [7:0]  DOUT;
   logic        BUSDIR_n, INT_n, WAIT_n;
   logic [16*NB-1:0] BANK_ADDR;
   logic [8*NB-1:0]  BANK_INIT;
   logic [15:0] BANK_ADDR_MASK;
   logic [7:0]  BANK_MASK;
   logic WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK, SCC_ENA, LOCKED;
   logic [31:0] MEM_TOP_ADDR;

   megarom_configure_multi #(
      .NUM_BANKS(NB), .BASE_ADDR(BASE), .RAM_ADDR(RADDR), .UNLOCK_TIMEOUT(TMO)
   ) dut (
      .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n), .SLTSL_n(SLTSL_n),
      .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n), .ADDR(ADDR), .DIN(DIN),
      .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .INT_n(INT_n), .WAIT_n(WAIT_n),
      .BANK_ADDR(BANK_ADDR), .BANK_INIT(BANK_INIT), .BANK_ADDR_MASK(BANK_ADDR_MASK),
      .BANK_MASK(BANK_MASK), .WRITE_PROTECT(WRITE_PROTECT), .IS_16K_BANK(IS_16K_BANK),
      .CS1_MASK(CS1_MASK), .CS2_MASK(CS2_MASK), .SCC_ENA(SCC_ENA),
      .MEM_TOP_ADDR(MEM_TOP_ADDR), .LOCKED(LOCKED)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register bytes indexed by window offset.
   logic [7:0] sh [0:63];
   logic [7:0] ac [0:63];
   logic [7:0] keys [0:3] = '{8'hAB, 8'hCD, 8'h98, 8'h76};
   int  kst;
   int  idle;
   bit  pend;
   bit  prev_we;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) sh[i] = 8'h00;
      sh[12] = 8'h0F;
      for (int b = 0; b < NB; b++) begin
         sh[16 + 4*b] = 8'hFF;
         sh[17 + 4*b] = 8'hFF;
      end
      ac = sh;
      kst = 0; idle = 0; pend = 1'b0; prev_we = 1'b1;
   endfunction

   function automatic bit in_win(input logic [15:0] a);
      return a[15:6] == BASE[15:6];
   endfunction

   function automatic void model_edge(input bit brst, input bit wedge,
                                      input logic [15:0] a, input logic [7:0] d);
      bit was_unl = (kst == 4);
      bit acc = 1'b0;
      int off = int'(a[5:0]);
      if (brst) begin
         kst = 0; pend = 1'b0; idle = 0;
         if (!ac[12][6]) begin
            ac[12][7] = 1'b0;
            sh[12][7] = 1'b0;
         end
         return;
      end
      if (pend) begin
         ac = sh;
         pend = 1'b0;
      end
      if (wedge && in_win(a)) begin
         if (was_unl) begin
            acc = 1'b1;
            if (off == 1) kst = 0;
            else if (off == 11) begin
               if (d[0]) pend = 1'b1;
            end else if (off >= 12 && off < 16 + 4*NB) sh[off] = d;
         end else if (off == 0) begin
            kst = (d == keys[kst]) ? kst + 1 : ((d == 8'hAB) ? 1 : 0);
         end else if (off == 1) begin
            kst = 0;
         end
      end
      if (was_unl) begin
         if (acc) idle = 0;
         else begin
            idle++;
            if (idle == TMO) begin
               kst = 0;
               idle = 0;
            end
         end
      end else begin
         idle = 0;
      end
   endfunction

   function automatic logic [8:0] exp_read(input logic [15:0] a);
      int off = int'(a[5:0]);
      if (!in_win(a)) return 9'h100;
      if (off == 0) return {1'b0, 4'(NB), 2'b00, pend, (kst == 4)};
      if (kst != 4) return 9'h100;
      if (off >= 12 && off < 16 + 4*NB) return {1'b0, sh[off]};
      return 9'h000;
   endfunction

   task automatic check_outputs();
      logic [7:0] f;
      f = ac[12];
      check_val("locked", LOCKED, (kst != 4));
      check_val("wp", WRITE_PROTECT, f[0]);
      check_val("is16k", IS_16K_BANK, f[1]);
      check_val("cs1", CS1_MASK, f[2] | !f[7]);
      check_val("cs2", CS2_MASK, f[3] | !f[7]);
      check_val("scc", SCC_ENA, f[4]);
      check_val("bank_mask", BANK_MASK, ac[13]);
      check_val("addr_mask", BANK_ADDR_MASK, {ac[15], ac[14]});
      check_val("top", MEM_TOP_ADDR, RADDR);
      check_val("int_wait", {INT_n, WAIT_n}, 2'b11);
      for (int b = 0; b < NB; b++) begin
         check_val($sformatf("bank_addr%0d", b), BANK_ADDR[16*b +: 16], {ac[17 + 4*b], ac[16 + 4*b]});
         check_val($sformatf("bank_init%0d", b), BANK_INIT[8*b +: 8], ac[18 + 4*b]);
      end
   endtask

   task automatic cycle(input bit brst, input bit we, input bit rd,
                        input logic [15:0] a, input logic [7:0] d);
      logic [8:0] er;
      bit wedge;
      BUS_RESET_n = !brst;
      SLTSL_n = !(we || rd);
      MERQ_n  = !(we || rd);
      WR_n = !we;
      RD_n = !rd;
      ADDR = a;
      DIN  = d;
      er = rd ? exp_read(a) : 9'h100;
      wedge = we && !prev_we;
      prev_we = brst ? 1'b1 : we;
      @(posedge CLK);
      model_edge(brst, wedge, a, d);
      #1;
      check_val("busdir_n", BUSDIR_n, er[8]);
      check_val("dout", DOUT, er[7:0]);
      check_outputs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, BASE, 8'h00);
   endtask

   task automatic bwrite(input logic [15:0] a, input logic [7:0] d, input int hold);
      for (int i = 0; i < hold; i++) cycle(1'b0, 1'b1, 1'b0, a, d);
      cycle(1'b0, 1'b0, 1'b0, a, d);
   endtask

   task automatic bread(input logic [15:0] a);
      cycle(1'b0, 1'b0, 1'b1, a, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, a, 8'h00);
   endtask

   task automatic bus_rst();
      cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, BASE, 8'h00);
   endtask

   task automatic unlock();
      for (int k = 0; k < 4; k++) bwrite(BASE, keys[k], 1);
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int r, s;
      model_reset();
      repeat (3) @(posedge CLK);
      #1 RESET_n = 1'b1;
      check_outputs();
      check_val("reset_busdir_n", BUSDIR_n, 1'b1);
      check_val("reset_dout", DOUT, 8'h00);

      // Locked read of FLAGS, then unlock and read status.
      bread(BASE + 16'h000C);
      unlock();
      bread(BASE);
      bwrite(BASE + 16'h0001, 8'h00, 1);
      for (int k = 0; k < 2; k++) bwrite(BASE, keys[k], 1);
      unlock();
      bread(BASE);

      // Shadow writes invisible until commit; long write strobe acts once.
      bwrite(BASE + 16'h0010, 8'h00, 1);
      bwrite(BASE + 16'h0011, 8'h60, 3);
      bwrite(BASE + 16'h000C, 8'h80, 2);
      bread(BASE + 16'h0011);
      bwrite(BASE + 16'h000B, 8'h01, 1);
      idle_cycles(2);

      // Idle timeout, then locked writes must be ignored.
      unlock();
      idle_cycles(105);
      bwrite(BASE + 16'h000C, 8'h5A, 1);
      bread(BASE + 16'h000C);

      // Bus reset with ENABLE_CONTINUOUS clear and set.
      unlock();
      bwrite(BASE + 16'h000C, 8'h80, 1);
      bwrite(BASE + 16'h000B, 8'h01, 1);
      bus_rst();
      unlock();
      bwrite(BASE + 16'h000C, 8'hC0, 1);
      bwrite(BASE + 16'h000B, 8'h01, 1);
      bus_rst();

      // Last bank and out-of-window aliases.
      unlock();
      bwrite(BASE + 16'h002C, 8'h34, 1);
      bwrite(BASE + 16'h002D, 8'h12, 1);
      bwrite(16'h7F80 + 16'h002C, 8'hEE, 1);
      bwrite(16'h7F80 + 16'h000C, 8'h00, 1);
      bwrite(BASE + 16'h000B, 8'h01, 1);
      idle_cycles(2);
      bread(16'h7F80);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            s = $urandom_range(0, 19);
            d = 8'($urandom_range(0, 255));
            if (s < 4) begin
               a = BASE;
               d = keys[$urandom_range(0, 3)];
            end else if (s == 4) a = BASE + 16'h0001;
            else if (s < 7) a = BASE + 16'h000B;
            else a = BASE + 16'($urandom_range(2, 63));
            bwrite(a, d, $urandom_range(1, 3));
         end else if (r < 50) begin
            unlock();
         end else if (r < 70) begin
            bread(BASE + 16'($urandom_range(0, 63)));
         end else if (r < 80) begin
            a = 16'($urandom_range(0, 65535));
            if (in_win(a)) a = a ^ 16'h0040;
            if ($urandom_range(0, 1) == 0) bwrite(a, 8'($urandom_range(0, 255)), 1);
            else bread(a);
         end else if (r < 83) begin
            bus_rst();
         end else begin
            idle_cycles($urandom_range(1, 5));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
